vera_bus_sequencer: RTL and testbench

Parametrised successor to the static VERA demo harness. The old harness held the VERA external bus idle. This block plays a script of register operations from a synchronous ROM onto the VERA external bus, using programmable setup/strobe/hold timing. It can wait for vertical blank between writes, jump within the script, and stop at an END entry. It also generates the pixel clock enable (ce_pix) and sits between the top-level wrapper and the vera instance.

---
 rtl/vera_seq_pkg.sv | 34 +++
 rtl/vera_ce_gen.sv | 25 ++
 rtl/vera_bus_sequencer.sv | 139 +++++++++++++
 tb/tb_vera_bus_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vera_seq_pkg.sv
// vera_seq_pkg: shared op codes, state encoding and width helpers for the VERA bus sequencer
package vera_seq_pkg;
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_WAIT_VB = 2'b01;
  localparam logic [1:0] OP_JUMP = 2'b10;
  localparam logic [1:0] OP_END = 2'b11;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_SETUP = 3'd3;
  localparam logic [2:0] ST_STROBE = 3'd4;
  localparam logic [2:0] ST_HOLD = 3'd5;
  localparam logic [2:0] ST_WAITVB = 3'd6;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    FETCH = ST_FETCH,
    DECODE = ST_DECODE,
    SETUP = ST_SETUP,
    STROBE = ST_STROBE,
    HOLD = ST_HOLD,
    WAITVB = ST_WAITVB
  } state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int max3(input int x, input int y, input int z);
    int m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction
endpackage

// File: rtl/vera_ce_gen.sv
// vera_ce_gen: pixel clock enable, constant under scandouble, else one pulse per CE_DIV clocks
module vera_ce_gen
  import vera_seq_pkg::*;
#(
  parameter int CE_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scandouble,
  output logic ce_pix
);
  localparam int CW = (CE_DIV > 1) ? clog2(CE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CE_DIV - 1);
  logic [CW-1:0] cnt, cnt_n;
  assign cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ce_pix <= 1'b0;
    end else begin
      cnt <= cnt_n;
      ce_pix <= scandouble || (cnt_n == LAST);
    end
  end
endmodule

// File: rtl/vera_bus_sequencer.sv
// vera_bus_sequencer: plays a ROM script of register writes onto the VERA external bus
module vera_bus_sequencer
  import vera_seq_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH = 256,
  parameter int SETUP_CYC = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC = 1,
  parameter int CE_DIV = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         scandouble,
  input  logic                         start,
  input  logic                         vblank,
  output logic [clog2(DEPTH)-1:0]      rom_addr,
  input  logic [2+ADDR_W+DATA_W-1:0]   rom_data,
  output logic                         ce_pix,
  output logic                         extbus_cs_n,
  output logic                         extbus_rd_n,
  output logic                         extbus_wr_n,
  output logic [ADDR_W-1:0]            extbus_a,
  output logic [DATA_W-1:0]            extbus_d_out,
  output logic                         extbus_d_oe,
  output logic                         busy,
  output logic                         done
);
  localparam int PC_W = clog2(DEPTH);
  localparam int TW = clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
  state_t state, state_n;
  logic [PC_W-1:0] pc, pc_n, pc_inc, tgt;
  logic [TW-1:0] tmr, tmr_n;
  logic [1:0] op;
  logic [ADDR_W-1:0] r_a, a_n;
  logic [DATA_W-1:0] r_d, d_n;
  logic cs_n_n, wr_n_n, d_oe_n, busy_n, done_n, vblank_q;
  assign {op, r_a, r_d} = rom_data;
  assign tgt = PC_W'(r_d);
  assign pc_inc = (pc == PC_W'(DEPTH - 1)) ? '0 : pc + 1'b1;
  // ROM address tracks pc, so the FETCH cycle covers the ROM's one-clock latency
  assign rom_addr = pc;
  assign extbus_rd_n = 1'b1;
  vera_ce_gen #(.CE_DIV(CE_DIV)) u_ce (
    .clk(clk),
    .reset(reset),
    .scandouble(scandouble),
    .ce_pix(ce_pix)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      tmr <= '0;
      extbus_cs_n <= 1'b1;
      extbus_wr_n <= 1'b1;
      extbus_a <= '0;
      extbus_d_out <= '0;
      extbus_d_oe <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      tmr <= tmr_n;
      extbus_cs_n <= cs_n_n;
      extbus_wr_n <= wr_n_n;
      extbus_a <= a_n;
      extbus_d_out <= d_n;
      extbus_d_oe <= d_oe_n;
      busy <= busy_n;
      done <= done_n;
      vblank_q <= vblank;
    end
  end
  always_comb begin
    state_n = state;
    pc_n = pc;
    tmr_n = tmr;
    cs_n_n = extbus_cs_n;
    wr_n_n = extbus_wr_n;
    a_n = extbus_a;
    d_n = extbus_d_out;
    d_oe_n = extbus_d_oe;
    busy_n = busy;
    done_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        pc_n = '0;
        busy_n = 1'b1;
        state_n = FETCH;
      end
      FETCH: state_n = DECODE;
      DECODE: case (op)
        OP_WRITE: begin
          a_n = r_a;
          d_n = r_d;
          cs_n_n = 1'b0;
          d_oe_n = 1'b1;
          tmr_n = TW'(SETUP_CYC - 1);
          state_n = SETUP;
        end
        OP_WAIT_VB: state_n = WAITVB;
        OP_JUMP: begin
          pc_n = tgt;
          state_n = FETCH;
        end
        default: begin
          busy_n = 1'b0;
          done_n = 1'b1;
          state_n = IDLE;
        end
      endcase
      SETUP: if (tmr == '0) begin
        wr_n_n = 1'b0;
        tmr_n = TW'(STROBE_CYC - 1);
        state_n = STROBE;
      end else tmr_n = tmr - 1'b1;
      STROBE: if (tmr == '0) begin
        wr_n_n = 1'b1;
        tmr_n = TW'(HOLD_CYC - 1);
        state_n = HOLD;
      end else tmr_n = tmr - 1'b1;
      HOLD: if (tmr == '0) begin
        cs_n_n = 1'b1;
        d_oe_n = 1'b0;
        pc_n = pc_inc;
        state_n = FETCH;
      end else tmr_n = tmr - 1'b1;
      WAITVB: if (vblank && !vblank_q) begin
        pc_n = pc_inc;
        state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_vera_bus_sequencer.sv
// tb_vera_bus_sequencer: scoreboard bench with an event-level script interpreter as reference
module tb_vera_bus_sequencer;
  localparam int S = 1, T = 2, H = 1;
  typedef struct {bit is_done; int t; logic [4:0] a; logic [7:0] d;} ev_t;
  logic clk = 0, reset = 1, scandouble = 0, start = 0, vblank = 1;
  logic [7:0] rom_addr;
  logic [14:0] rom_data;
  logic ce_pix, cs_n, rd_n, wr_n, d_oe, busy, done;
  logic [4:0] a;
  logic [7:0] d_out;
  logic [7:0] rom_addr2;
  logic [14:0] rom_data2 = {2'b11, 13'd0};
  logic ce4, cs_n2, rd_n2, wr_n2, d_oe2, busy2, done2;
  logic [4:0] a2;
  logic [7:0] d2;
  logic [14:0] rom [256];
  ev_t sb[$];
  int cyc = 0, rc = 0, n_cmp = 0, n_bad = 0, vf = 0, vr = 0;
  int cl = 0, wl = 0;
  logic [4:0] wa;
  logic [7:0] wd;
  logic pcs = 1, pwr = 1, pbusy = 0;

  vera_bus_sequencer #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .CE_DIV(2)) dut (
    .clk(clk), .reset(reset), .scandouble(scandouble), .start(start), .vblank(vblank),
    .rom_addr(rom_addr), .rom_data(rom_data), .ce_pix(ce_pix), .extbus_cs_n(cs_n),
    .extbus_rd_n(rd_n), .extbus_wr_n(wr_n), .extbus_a(a), .extbus_d_out(d_out),
    .extbus_d_oe(d_oe), .busy(busy), .done(done)
  );
  vera_bus_sequencer #(.CE_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .scandouble(1'b0), .start(1'b0), .vblank(1'b0),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .ce_pix(ce4), .extbus_cs_n(cs_n2),
    .extbus_rd_n(rd_n2), .extbus_wr_n(wr_n2), .extbus_a(a2), .extbus_d_out(d2),
    .extbus_d_oe(d_oe2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [14:0] ent(input logic [1:0] op, input logic [4:0] ad, input logic [7:0] dd);
    return {op, ad, dd};
  endfunction
  function automatic bit vb(input int x);
    return !(x >= vf && x < vr);
  endfunction
  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Script interpreter: cost of each entry in clocks, event times in edge numbers
  function automatic bit model(input int s0, input int hz);
    int t, pc, e;
    logic [14:0] r;
    t = s0;
    pc = 0;
    for (int k = 0; k < 4000 && t <= hz; k++) begin
      r = rom[pc];
      case (r[14:13])
        2'd0: begin
          e = t + 2 + S + T;
          if (e <= hz) sb.push_back('{1'b0, e, r[12:8], r[7:0]});
          t += 2 + S + T + H;
          pc = (pc + 1) % 256;
        end
        2'd1: begin
          e = -1;
          for (int x = t + 3; x <= hz && e < 0; x++) if (vb(x) && !vb(x - 1)) e = x;
          if (e < 0) return 1'b0;
          t = e;
          pc = (pc + 1) % 256;
        end
        2'd2: begin
          t += 2;
          pc = int'(r[7:0]);
        end
        default: begin
          if (t + 2 <= hz) begin
            sb.push_back('{1'b1, t + 2, 5'd0, 8'd0});
            return 1'b1;
          end
          return 1'b0;
        end
      endcase
    end
    return 1'b0;
  endfunction

  task automatic ev(input bit isd);
    ev_t e;
    if (sb.size() == 0) chk(1'b0, "unexpected_event", 64'({isd, cyc[23:0], a, d_out}), 64'd0);
    else begin
      e = sb.pop_front();
      if (isd) chk(e.is_done && e.t == cyc && !busy && pbusy, "done_event",
                   64'({isd, cyc[23:0], busy, pbusy}), 64'({e.is_done, e.t[23:0], 2'b01}));
      else chk(!e.is_done && e.t == cyc && a == e.a && d_out == e.d, "write_event",
               64'({isd, cyc[23:0], a, d_out}), 64'({e.is_done, e.t[23:0], e.a, e.d}));
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      rc = 0;
      chk(cs_n && wr_n && rd_n && !d_oe && !busy && !done && !ce_pix, "reset_idle",
          64'({cs_n, wr_n, rd_n, d_oe, busy, done, ce_pix}), 64'(7'b1110000));
      pcs = 1;
      pwr = 1;
      pbusy = 0;
    end else begin
      rc++;
      chk(ce_pix == (scandouble || rc % 2 == 1), "ce_pix_div2", 64'(ce_pix), 64'(scandouble || rc % 2 == 1));
      chk(ce4 == (rc % 4 == 3), "ce_pix_div4", 64'(ce4), 64'(rc % 4 == 3));
      chk({rom_addr2, cs_n2, wr_n2, rd_n2, d_oe2, busy2, done2, a2, d2} == {8'd0, 6'b111000, 13'd0},
          "div4_inst_idle", 64'({rom_addr2, cs_n2, wr_n2, rd_n2, d_oe2, busy2, done2, a2, d2}),
          64'({8'd0, 6'b111000, 13'd0}));
      if (!wr_n) chk(!cs_n, "wr_inside_cs", 64'(cs_n), 64'd0);
      if (!cs_n) begin
        if (pcs) begin
          wa = a;
          wd = d_out;
          cl = 0;
          wl = 0;
        end else chk(a == wa && d_out == wd && d_oe, "bus_stable",
                     64'({d_oe, a, d_out}), 64'({1'b1, wa, wd}));
        cl++;
        if (!wr_n) wl++;
        if (pwr && !wr_n) chk(cl - 1 == S, "setup_len", 64'(cl - 1), 64'(S));
      end else if (!pcs) chk(cl == S + T + H && wl == T && !d_oe, "window_len",
                             64'({cl[15:0], wl[15:0], d_oe}), 64'({16'(S + T + H), 16'(T), 1'b0}));
      if (!pwr && wr_n) ev(1'b0);
      if (done) ev(1'b1);
      pcs = cs_n;
      pwr = wr_n;
      pbusy = busy;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = ent(2'b11, 5'd0, 8'd0);
  endtask

  task automatic run_test(input int len, input int vf_off, input int vr_off, input bit mid_start);
    int s0;
    bit ended;
    @(negedge clk) reset = 0;
    repeat (2) @(negedge clk);
    s0 = cyc + 1;
    vf = vf_off ? s0 + vf_off : 0;
    vr = vf_off ? s0 + vr_off : 0;
    ended = model(s0, s0 + len);
    vblank = vb(s0);
    start = 1;
    @(negedge clk);
    start = 0;
    while (cyc < s0 + len) begin
      vblank = vb(cyc + 1);
      start = mid_start && (cyc + 1 == s0 + len / 2);
      @(negedge clk);
    end
    chk(busy == !ended, "busy_at_end", 64'(busy), 64'(!ended));
    reset = 1;
    start = 0;
    repeat (2) @(negedge clk);
    chk(sb.size() == 0, "events_outstanding", 64'(sb.size()), 64'd0);
    sb.delete();
    vf = 0;
    vr = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, r, fo, ro, k;
    bit wv;
    clear_rom();
    repeat (3) @(negedge clk);
    rom[0] = ent(2'b00, 5'h00, 8'h12);
    reset = 0;
    repeat (6) @(negedge clk);
    chk(cs_n && !busy && rom_addr == 0, "idle_without_start", 64'({cs_n, busy, rom_addr}), 64'({2'b10, 8'd0}));
    reset = 1;
    repeat (2) @(negedge clk);
    clear_rom();
    rom[0] = ent(2'b00, 5'h00, 8'hAA);
    rom[1] = ent(2'b00, 5'h03, 8'h55);
    run_test(30, 0, 0, 0);
    clear_rom();
    rom[0] = ent(2'b01, 5'd0, 8'd0);
    rom[1] = ent(2'b00, 5'h01, 8'h7F);
    run_test(40, 4, 9, 0);
    clear_rom();
    rom[0] = ent(2'b00, 5'h02, 8'h01);
    rom[1] = ent(2'b10, 5'd0, 8'h00);
    run_test(60, 0, 0, 1);
    clear_rom();
    rom[0] = ent(2'b00, 5'h0A, 8'h3C);
    rom[1] = ent(2'b10, 5'd0, 8'hFF);
    rom[255] = ent(2'b00, 5'h15, 8'hC3);
    run_test(60, 0, 0, 0);
    clear_rom();
    rom[0] = ent(2'b00, 5'h1F, 8'hA5);
    @(negedge clk) reset = 0;
    repeat (2) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    k = 0;
    while (wr_n !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(k < 20, "strobe_reached", 64'(k), 64'd20);
    reset = 1;
    #1;
    chk(cs_n && wr_n && !d_oe, "async_bus_release", 64'({cs_n, wr_n, d_oe}), 64'(3'b110));
    @(negedge clk) reset = 0;
    repeat (3) @(negedge clk);
    chk(rom_addr == 0 && !busy && cs_n, "idle_after_abort", 64'({rom_addr, busy, cs_n}), 64'({8'd0, 2'b01}));
    reset = 1;
    repeat (2) @(negedge clk);
    chk(sb.size() == 0, "no_events_abort", 64'(sb.size()), 64'd0);
    for (int tn = 0; tn < 8; tn++) begin
      clear_rom();
      n = 2 + int'($urandom % 5);
      wv = 0;
      for (int i = 0; i < n - 1; i++) begin
        r = int'($urandom % 8);
        if (r == 7 && !wv) begin
          rom[i] = ent(2'b01, 5'd0, 8'd0);
          wv = 1;
        end else if (r == 6) rom[i] = ent(2'b10, 5'd0, 8'(i + 1));
        else rom[i] = ent(2'b00, 5'($urandom), 8'($urandom));
      end
      fo = 3 + int'($urandom % 10);
      ro = fo + 1 + int'($urandom % 10);
      scandouble = (tn % 3 == 1);
      run_test(120, wv ? fo : 0, wv ? ro : 0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
